m_ifetch_queue: RTL and testbench

//  Instruction-fetch front end of the 5-stage MIPS pipeline; sits directly upstream of the ID stage.

---
 rtl/m_ifetch_queue_pkg.sv | 18 +
 rtl/m_fetch_fifo.sv | 79 +++++++
 rtl/m_ifetch_queue.sv | 94 +++++++++
 tb/tb_m_ifetch_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: entry layout,
// default encodings and a small PC helper.
package m_ifetch_queue_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam int          ENTRY_W          = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, ir} entries. Flush empties it with the
// same priority as reset; the valid flag is registered alongside the count.
module m_fetch_fifo
    import m_ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [ENTRY_W-1:0]           wdata_i,
    input  logic                         pop_i,
    output logic [ENTRY_W-1:0]           rdata_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               valid_q, valid_d;
    logic               do_push, do_pop;

    always_comb begin
        // NOTE: every variable gets a default first so no latch can be inferred.
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/m_ifetch_queue.sv
// Instruction-fetch front end: owns the PC, issues reads to a 1-cycle imem and
// buffers returned {pc, ir} pairs for ID with credit-based flow control.
module m_ifetch_queue
    import m_ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 12,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                        w_clk,
    input  logic                        w_rst_n,
    output logic [AW-1:0]               w_imem_addr,
    output logic                        r_imem_re,
    input  logic [31:0]                 w_imem_rdata,
    input  logic                        w_redir,
    input  logic [31:0]                 w_redir_pc,
    input  logic                        w_halt,
    output logic                        r_valid,
    input  logic                        w_ready,
    output logic [31:0]                 w_ir,
    output logic [31:0]                 w_pc,
    output logic [31:0]                 w_pc4,
    output logic [$clog2(DEPTH+1)-1:0]  r_count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;
    logic [CW:0]        credits_used;
    logic               issue;
    logic               push;
    logic               pop;
    fetch_entry_t       wr_entry;
    fetch_entry_t       head;
    logic [ENTRY_W-1:0] head_raw;

    // A read is only issued when the queue is guaranteed room for its return.
    always_comb begin
        credits_used  = {1'b0, r_count} + {{CW{1'b0}}, inflight_q};
        issue         = w_rst_n && !w_halt && !w_redir && (credits_used < (CW+1)'(DEPTH));
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;

        if (w_redir) begin
            pc_d = word_align(w_redir_pc);
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Returning data is dropped when a redirect flushes the queue this cycle.
    assign push     = inflight_q && !w_redir;
    assign pop      = r_valid && w_ready;
    assign wr_entry = '{pc: inflight_pc_q, ir: w_imem_rdata};

    m_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (w_clk),
        .rst_n   (w_rst_n),
        .flush_i (w_redir),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .valid_o (r_valid),
        .count_o (r_count)
    );

    assign head        = head_raw;
    assign w_imem_addr = pc_q[AW+1:2];
    assign r_imem_re   = issue;
    assign w_pc        = head.pc;
    assign w_pc4       = head.pc + 32'd4;
    assign w_ir        = r_valid ? head.ir : NOP;

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Self-checking bench for m_ifetch_queue: queue-level reference model compared
// every cycle, directed scenarios pinned with literal values, then random traffic.
module tb_m_ifetch_queue;

    localparam int          DEPTH  = 4;
    localparam int          AW     = 12;
    localparam int          CW     = $clog2(DEPTH+1);
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          w_clk = 1'b0;
    logic          w_rst_n;
    logic [AW-1:0] w_imem_addr;
    logic          r_imem_re;
    logic [31:0]   w_imem_rdata = 32'h0;
    logic          w_redir;
    logic [31:0]   w_redir_pc;
    logic          w_halt;
    logic          r_valid;
    logic          w_ready;
    logic [31:0]   w_ir;
    logic [31:0]   w_pc;
    logic [31:0]   w_pc4;
    logic [CW-1:0] r_count;

    m_ifetch_queue #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RESET_PC (RST_PC)
    ) dut (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .w_imem_addr  (w_imem_addr),
        .r_imem_re    (r_imem_re),
        .w_imem_rdata (w_imem_rdata),
        .w_redir      (w_redir),
        .w_redir_pc   (w_redir_pc),
        .w_halt       (w_halt),
        .r_valid      (r_valid),
        .w_ready      (w_ready),
        .w_ir         (w_ir),
        .w_pc         (w_pc),
        .w_pc4        (w_pc4),
        .r_count      (r_count)
    );

    always #5 w_clk = ~w_clk;

    // Instruction memory: mem[i] = 1000_0000 + i, one cycle read latency.
    logic [31:0] imem [1 << AW];
    always @(posedge w_clk) begin
        if (r_imem_re) w_imem_rdata <= imem[w_imem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: PC, one optional outstanding fetch, and a queue of fetched PCs.
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_q [$];
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = RST_PC;
    bit          model_on = 1'b0;

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return 32'h1000_0000 + 32'(pc[AW+1:2]);
    endfunction

    function automatic bit m_issue();
        return w_rst_n && !w_halt && !w_redir && ((m_q.size() + int'(m_infl)) < DEPTH);
    endfunction

    always @(posedge w_clk) begin
        bit iss;
        bit pop;
        iss = m_issue();
        pop = (m_q.size() != 0) && w_ready;
        if (!w_rst_n) begin
            m_pc     = RST_PC;
            m_q.delete();
            m_infl   = 1'b0;
            model_on = 1'b1;
        end else if (w_redir) begin
            m_pc   = w_redir_pc & 32'hFFFF_FFFC;
            m_q.delete();
            m_infl = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = iss;
            if (iss) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    end

    always @(negedge w_clk) begin
        if (model_on) begin
            check("imem_re", 32'(r_imem_re), 32'(m_issue()));
            check("imem_addr", 32'(w_imem_addr), 32'(m_pc[AW+1:2]));
            check("count", 32'(r_count), 32'(m_q.size()));
            check("valid", 32'(r_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("head_pc", w_pc, m_q[0]);
                check("head_ir", w_ir, ir_of(m_q[0]));
                check("head_pc4", w_pc4, m_q[0] + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    int halt_len;

    initial begin
        for (int i = 0; i < (1 << AW); i++) imem[i] = 32'h1000_0000 + i;
        w_rst_n    = 1'b0;
        w_ready    = 1'b1;
        w_halt     = 1'b0;
        w_redir    = 1'b0;
        w_redir_pc = 32'h0;
        tick();
        tick();

        // Start-up: sequential addresses, first valid two cycles after first issue.
        w_rst_n = 1'b1;
        #1;
        check("t1_re0", 32'(r_imem_re), 32'd1);
        check("t1_addr0", 32'(w_imem_addr), 32'h0);
        check("t1_valid0", 32'(r_valid), 32'd0);
        tick(); #1;
        check("t1_addr1", 32'(w_imem_addr), 32'h1);
        tick(); #1;
        check("t1_valid", 32'(r_valid), 32'd1);
        check("t1_pc", w_pc, 32'h0);
        check("t1_ir", w_ir, 32'h1000_0000);
        check("t1_pc4", w_pc4, 32'h4);
        tick(); #1;
        check("t1_pc_next", w_pc, 32'h4);
        check("t1_ir_next", w_ir, 32'h1000_0001);

        // Backpressure: queue fills, issue stops, head holds.
        w_ready = 1'b0;
        repeat (10) tick();
        #1;
        check("t2_count", 32'(r_count), 32'd4);
        check("t2_re", 32'(r_imem_re), 32'd0);
        check("t2_head_pc", w_pc, 32'h4);
        check("t2_head_ir", w_ir, 32'h1000_0001);
        w_ready = 1'b1;
        repeat (8) tick();

        // Redirect with 3 queued and 1 in flight.
        w_rst_n = 1'b0;
        tick();
        w_rst_n = 1'b1;
        w_ready = 1'b0;
        repeat (4) tick();
        #1;
        check("t3_count3", 32'(r_count), 32'd3);
        check("t3_re_blocked", 32'(r_imem_re), 32'd0);
        w_redir    = 1'b1;
        w_redir_pc = 32'h0000_0043;
        tick();
        w_redir = 1'b0;
        #1;
        check("t3_valid0", 32'(r_valid), 32'd0);
        check("t3_count0", 32'(r_count), 32'd0);
        check("t3_addr", 32'(w_imem_addr), 32'h10);
        check("t3_re", 32'(r_imem_re), 32'd1);
        tick(); tick(); #1;
        check("t3_valid", 32'(r_valid), 32'd1);
        check("t3_pc", w_pc, 32'h40);
        check("t3_ir", w_ir, 32'h1000_0010);

        // Redirect while a pop is happening.
        w_ready = 1'b1;
        repeat (4) tick();
        #1;
        check("t4_valid_before", 32'(r_valid), 32'd1);
        w_redir    = 1'b1;
        w_redir_pc = 32'h0000_0100;
        tick();
        w_redir = 1'b0;
        #1;
        check("t4_count", 32'(r_count), 32'd0);
        check("t4_valid", 32'(r_valid), 32'd0);

        // Halt: issue stops, PC holds, queue drains; redirect during halt.
        repeat (3) tick();
        w_halt = 1'b1;
        #1;
        check("t5_addr_start", 32'(w_imem_addr), 32'h43);
        check("t5_re_start", 32'(r_imem_re), 32'd0);
        repeat (8) tick();
        #1;
        check("t5_addr_held", 32'(w_imem_addr), 32'h43);
        check("t5_count", 32'(r_count), 32'd0);
        check("t5_valid", 32'(r_valid), 32'd0);
        w_redir    = 1'b1;
        w_redir_pc = 32'h0000_0080;
        #1;
        check("t5_re_redir", 32'(r_imem_re), 32'd0);
        tick();
        w_redir = 1'b0;
        w_halt  = 1'b0;
        #1;
        check("t5_addr_new", 32'(w_imem_addr), 32'h20);
        check("t5_re_new", 32'(r_imem_re), 32'd1);

        // Mid-operation reset with entries queued and a fetch in flight.
        w_ready = 1'b0;
        repeat (4) tick();
        #1;
        check("t6_count3", 32'(r_count), 32'd3);
        w_rst_n = 1'b0;
        tick();
        w_rst_n = 1'b1;
        #1;
        check("t6_count0", 32'(r_count), 32'd0);
        check("t6_valid0", 32'(r_valid), 32'd0);
        check("t6_addr0", 32'(w_imem_addr), 32'h0);
        check("t6_re", 32'(r_imem_re), 32'd1);
        tick(); tick(); #1;
        check("t6_pc", w_pc, 32'h0);
        check("t6_ir", w_ir, 32'h1000_0000);

        // Random traffic, including PC and imem-address wraparound targets.
        halt_len = 0;
        for (int c = 0; c < 3000; c++) begin
            w_rst_n = ($urandom_range(0, 99) != 0);
            w_redir = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       w_redir_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       w_redir_pc = 32'h0000_3FF0 | 32'($urandom_range(0, 15));
                default: w_redir_pc = $urandom;
            endcase
            if (halt_len == 0 && $urandom_range(0, 19) == 0) halt_len = $urandom_range(1, 10);
            w_halt = (halt_len > 0);
            if (halt_len > 0) halt_len--;
            w_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        w_rst_n = 1'b1;
        w_redir = 1'b0;
        w_halt  = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
